// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl: dot-product sequencer and accumulator closing the MAC feedback loop; MAC_DOT_SAT_EN selects saturating feedback
module mac_dot_ctrl #(
  parameter int VEC_LEN = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic [15:0] mac_acc_in,
  input  logic [31:0] mac_acc_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf
);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [15:0] acc_reg, acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0] res_nxt;
  logic accept, last, hi;
  assign busy = state != IDLE;
  assign in_ready = state == ACCUM;
  assign out_valid = state == DONE;
  assign mac_a = in_a;
  assign mac_b = in_b;
  assign mac_acc_in = acc_reg;
  assign accept = in_valid & in_ready;
  assign last = cnt == CNT_W'(VEC_LEN - 1);
  assign hi = |mac_acc_out[31:16];
`ifdef MAC_DOT_SAT_EN
  assign acc_nxt = hi ? 16'hFFFF : mac_acc_out[15:0];
  assign res_nxt = hi ? 32'h0000FFFF : mac_acc_out;
`else
  assign acc_nxt = mac_acc_out[15:0];
  assign res_nxt = mac_acc_out;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc_reg <= '0;
      cnt <= '0;
      out_result <= '0;
      out_ovf <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        state <= ACCUM;
        acc_reg <= '0;
        cnt <= '0;
        out_ovf <= 1'b0;
      end
      if (accept) begin
        acc_reg <= acc_nxt;
        out_ovf <= out_ovf | hi;
        cnt <= cnt + 1'b1;
        if (last) begin
          out_result <= res_nxt;
          state <= DONE;
        end
      end
      if (state == DONE && out_ready) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb_mac_dot_ctrl: randomized and directed checks of mac_dot_ctrl against a behavioural dot-product model
module tb_mac_dot_ctrl;
  localparam int VL = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start1 = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic busy, in_ready, out_valid, out_ovf, busy1, in_ready1, out_valid1, out_ovf1;
  logic [15:0] mac_a, mac_b, mac_acc_in, mac_a1, mac_b1, mac_acc_in1;
  logic [31:0] mac_acc_out, out_result, mac_acc_out1, out_result1;
  int checks = 0, failures = 0;
  int ph = 0, n = 0;
  logic [15:0] m_acc = '0;
  logic [31:0] m_res = '0, full;
  logic m_ovf = 1'b0;
  always #5 clk = ~clk;
  assign mac_acc_out = 32'(mac_a) * 32'(mac_b) + 32'(mac_acc_in);
  assign mac_acc_out1 = 32'(mac_a1) * 32'(mac_b1) + 32'(mac_acc_in1);
  mac_dot_ctrl #(.VEC_LEN(VL), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b), .mac_acc_in(mac_acc_in),
    .mac_acc_out(mac_acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf));
  mac_dot_ctrl #(.VEC_LEN(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .mac_a(mac_a1), .mac_b(mac_b1), .mac_acc_in(mac_acc_in1),
    .mac_acc_out(mac_acc_out1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_result(out_result1), .out_ovf(out_ovf1));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; n = 0; m_acc = '0; m_res = '0; m_ovf = 1'b0;
    end else if (ph == 0) begin
      if (start) begin ph = 1; n = 0; m_acc = '0; m_ovf = 1'b0; end
    end else if (ph == 1) begin
      if (in_valid) begin
        full = 32'(in_a) * 32'(in_b) + 32'(m_acc);
        m_ovf = m_ovf | (full > 32'h0000FFFF);
`ifdef MAC_DOT_SAT_EN
        if (full > 32'h0000FFFF) full = 32'h0000FFFF;
`endif
        m_acc = 16'(full % 65536);
        n++;
        if (n == VL) begin ph = 2; m_res = full; end
      end
    end else if (out_ready) ph = 0;
  end
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy", 32'(busy), 32'(ph != 0));
      chk("in_ready", 32'(in_ready), 32'(ph == 1));
      chk("out_valid", 32'(out_valid), 32'(ph == 2));
      chk("mac_acc_in", 32'(mac_acc_in), 32'(m_acc));
      chk("mac_ab", {mac_a, mac_b}, {in_a, in_b});
      if (ph == 2) begin
        chk("out_result", out_result, m_res);
        chk("out_ovf", 32'(out_ovf), 32'(m_ovf));
      end
    end
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic send(input logic [15:0] a, input logic [15:0] b, input int idle);
    repeat (idle) begin in_valid = 1'b0; step(); end
    in_valid = 1'b1; in_a = a; in_b = b;
    step();
    in_valid = 1'b0;
  endtask
  task automatic release_result(input string nm);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk(nm, 32'(busy), 32'd0);
  endtask
  initial begin
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out", {31'd0, out_valid} | 32'(out_ovf) | out_result, 0);
    chk("rst_acc", 32'(mac_acc_in), 0);
    step(); rst_n = 1'b1; step();
    do_start();
    in_valid = 1'b1; in_a = 16'd5; in_b = 16'd6;
    chk("s1_acc0", 32'(mac_acc_in), 32'h0);
    step(); in_a = 16'd2; in_b = 16'd3;
    chk("s1_acc1", 32'(mac_acc_in), 32'h1E);
    step(); in_a = 16'd8; in_b = 16'd9;
    chk("s1_acc2", 32'(mac_acc_in), 32'h24);
    chk("s1_not_yet", 32'(out_valid), 0);
    step(); in_valid = 1'b0;
    chk("s1_latency", 32'(out_valid), 1);
    chk("s1_result", out_result, 32'h6C);
    chk("s1_ovf", 32'(out_ovf), 0);
    release_result("s1_idle");
    step();
    do_start();
    send(16'd5, 16'd6, 0); send(16'd2, 16'd3, 0); send(16'd8, 16'd9, 0);
    repeat (5) begin
      chk("s2_hold", {out_result[29:0], out_valid, busy}, {30'h6C, 2'b11});
      chk("s2_in_ready", 32'(in_ready), 0);
      step();
    end
    release_result("s2_idle");
    do_start();
    send(16'd5, 16'd6, 0); send(16'd2, 16'd3, 2); send(16'd8, 16'd9, 1);
    chk("s3_result", out_result, 32'h6C);
    release_result("s3_idle");
    do_start();
    send(16'h0100, 16'h0100, 0); send(16'd1, 16'd1, 0); send(16'd2, 16'd2, 0);
`ifdef MAC_DOT_SAT_EN
    chk("s4_result", out_result, 32'h0000FFFF);
`else
    chk("s4_result", out_result, 32'h00000005);
`endif
    chk("s4_ovf", 32'(out_ovf), 1);
    release_result("s4_idle");
    do_start();
    send(16'd5, 16'd6, 0); send(16'd2, 16'd3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async", {busy, in_ready, mac_acc_in}, 0);
    step(); rst_n = 1'b1; step();
    do_start();
    send(16'd5, 16'd6, 0); send(16'd2, 16'd3, 0); send(16'd8, 16'd9, 0);
    chk("s5_fresh", out_result, 32'h6C);
    release_result("s5_idle");
    do_start();
    start = 1'b1;
    send(16'd5, 16'd6, 0); send(16'd2, 16'd3, 0); send(16'd8, 16'd9, 0);
    step(); step();
    chk("s6_result", out_result, 32'h6C);
    chk("s6_state", {out_valid, busy}, 32'h3);
    release_result("s6_exit_start");
    start = 1'b0;
    step();
    chk("s6_no_restart", 32'(busy), 0);
    start1 = 1'b1; step(); start1 = 1'b0;
    chk("v1_ready", 32'(in_ready1), 1);
    send(16'd7, 16'd9, 0);
    chk("v1_done", {out_valid1, out_ovf1}, 32'h2);
    chk("v1_result", out_result1, 32'd63);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("v1_idle", 32'(busy1), 0);
    for (int r = 0; r < 40; r++) begin
      int beats, mode;
      do_start();
      beats = 0;
      while (beats < VL) begin
        mode = $urandom % 3;
        start = ($urandom % 5) == 0;
        in_valid = ($urandom % 3) != 0;
        in_a = mode == 0 ? 16'($urandom_range(0, 15)) : mode == 1 ? 16'($urandom) : 16'($urandom_range(0, 255));
        in_b = mode == 0 ? 16'($urandom_range(0, 15)) : mode == 1 ? 16'($urandom) : 16'($urandom_range(0, 255));
        if (in_valid) beats++;
        step();
      end
      in_valid = 1'b0; start = 1'b0;
      chk("rnd_done", 32'(out_valid), 1);
      repeat ($urandom % 3) step();
      out_ready = 1'b1; start = ($urandom % 2) == 0;
      step();
      out_ready = 1'b0; start = 1'b0;
      chk("rnd_idle", 32'(busy), 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
endmodule
